// File: rtl/fns_cac_pkg.sv
// Shared constants and the FNS codeword decode helper for the 2+2 FNS
// crosstalk-avoidance receive path.
//   CODE_W     : TSV codeword width
//   DEF_DATA_W : default decoded chunk width
//   DEF_FNS_W  : default width of the FNS03/FNS04 weights
//   DEC_W      : widened decode sum width (never truncates)
//   DATA_MAX   : largest value a default-width chunk can hold
package fns_cac_pkg;

  localparam int unsigned CODE_W     = 4;
  localparam int unsigned DEF_DATA_W = 3;
  localparam int unsigned DEF_FNS_W  = 3;
  localparam int unsigned DEC_W      = DEF_DATA_W + 2;
  localparam int unsigned DATA_MAX   = (1 << DEF_DATA_W) - 1;

  // Weighted sum of the enabled codeword bits; disabled TSVs contribute 0.
  function automatic logic [DEC_W-1:0] fns_decode(
    input logic [CODE_W-1:0]    code,
    input logic [CODE_W-1:0]    en,
    input logic                 f2,
    input logic [DEF_FNS_W-1:0] f3,
    input logic [DEF_FNS_W-1:0] f4
  );
    logic [CODE_W-1:0] m;
    logic [DEC_W-1:0]  s;
    m = code & en;
    s = DEC_W'(m[0]);
    if (m[1]) s = s + DEC_W'(f2);
    if (m[2]) s = s + DEC_W'(f3);
    if (m[3]) s = s + DEC_W'(f4);
    return s;
  endfunction

endpackage

// File: rtl/fns_frame_fifo.sv
// Small frame FIFO with synchronous push/pop. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
//   clock, rst_n : clock, async active-low reset
//   push, din    : write request and frame
//   pop          : read request (ignored when empty)
//   dout         : head entry, read straight from storage
//   full, empty  : registered occupancy flags
module fns_frame_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next_c;
  logic             wr_c;
  logic             rd_c;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake qualification and next occupancy.
  always_comb begin
    rd_c         = pop & ~empty;
    wr_c         = push & (~full | rd_c);
    count_next_c = count;
    if (wr_c && !rd_c)      count_next_c = count + CNT_W'(1);
    else if (rd_c && !wr_c) count_next_c = count - CNT_W'(1);
  end

  // Storage, pointers and flags.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_c) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc_ptr(wr_ptr);
      end
      if (rd_c) rd_ptr <= inc_ptr(rd_ptr);
      count <= count_next_c;
      full  <= (count_next_c == CNT_W'(DEPTH));
      empty <= (count_next_c == '0);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fns_cac_decoder_2_2.sv
// Receive stage of the 2+2 FNS crosstalk-avoidance link: decodes each TSV
// codeword to a binary chunk, packs FRAME_N chunks into a frame and hands
// frames to the consumer through a small FIFO. The TSV side never stalls,
// so frames completing into a full FIFO are dropped and flagged.
//   clock, rst_n        : clock, async active-low reset
//   code_in, code_valid : TSV codeword and its strobe
//   en_flag             : per-TSV enable mask
//   FNS02/FNS03/FNS04   : FNS weights of codeword bits 1..3
//   resync              : discard the partially assembled frame
//   err_clr             : clear sticky flags (a same-cycle set wins)
//   frame_out/valid/ready : frame handshake, chunk 0 in the LSBs
//   overflow, range_err : sticky error flags
module fns_cac_decoder_2_2
  import fns_cac_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned FNS_W   = DEF_FNS_W,
  parameter int unsigned FRAME_N = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [CODE_W-1:0]         code_in,
  input  logic                      code_valid,
  input  logic [CODE_W-1:0]         en_flag,
  input  logic                      FNS02,
  input  logic [FNS_W-1:0]          FNS03,
  input  logic [FNS_W-1:0]          FNS04,
  input  logic                      resync,
  input  logic                      err_clr,
  output logic [FRAME_N*DATA_W-1:0] frame_out,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic                      overflow,
  output logic                      range_err
);

  localparam int unsigned VAL_W   = DATA_W + 2;
  localparam int unsigned FRAME_W = FRAME_N * DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_N);
  localparam int unsigned VAL_MAX = (DATA_W == DEF_DATA_W) ? DATA_MAX : (1 << DATA_W) - 1;

  logic [VAL_W-1:0]   dec_sum_c;
  logic               dec_sat_c;
  logic [DATA_W-1:0]  dec_val;
  logic               dec_vld;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] asm;
  logic [FRAME_W-1:0] asm_next_c;
  logic               chunk_c;
  logic               last_c;
  logic               pop_c;
  logic               drop_c;
  logic               fifo_full;
  logic               fifo_empty;

  // Widened FNS sum and range check for the incoming codeword.
  always_comb begin
    dec_sum_c = VAL_W'(fns_decode(code_in, en_flag, FNS02,
                                  DEF_FNS_W'(FNS03), DEF_FNS_W'(FNS04)));
    dec_sat_c = (dec_sum_c > VAL_W'(VAL_MAX));
  end

  // Decode register: saturate out-of-range values to all-ones.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dec_val <= '0;
      dec_vld <= 1'b0;
    end else begin
      dec_vld <= code_valid;
      if (code_valid) dec_val <= dec_sat_c ? '1 : DATA_W'(dec_sum_c);
    end
  end

  // Assembly: resync suppresses the chunk arriving in its cycle, so a final
  // chunk coinciding with resync never produces a push.
  always_comb begin
    chunk_c    = dec_vld & ~resync;
    last_c     = chunk_c && (cnt == CNT_W'(FRAME_N - 1));
    asm_next_c = asm;
    for (int i = 0; i < int'(FRAME_N); i++) begin
      if (cnt == CNT_W'(i)) asm_next_c[i*DATA_W +: DATA_W] = dec_val;
    end
    pop_c  = ~fifo_empty & frame_ready;
    drop_c = last_c & fifo_full & ~pop_c;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      asm <= '0;
      cnt <= '0;
    end else if (resync) begin
      cnt <= '0;
    end else if (chunk_c) begin
      asm <= asm_next_c;
      cnt <= last_c ? '0 : cnt + CNT_W'(1);
    end
  end

  // Sticky flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (code_valid && dec_sat_c) range_err <= 1'b1;
      else if (err_clr)            range_err <= 1'b0;
      if (drop_c)                  overflow  <= 1'b1;
      else if (err_clr)            overflow  <= 1'b0;
    end
  end

  fns_frame_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(FRAME_W)
  ) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (last_c),
    .pop   (frame_ready),
    .din   (asm_next_c),
    .dout  (frame_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign frame_valid = ~fifo_empty;

endmodule

// File: tb/tb_fns_cac_decoder_2_2.sv
module tb_fns_cac_decoder_2_2;

  localparam int unsigned DW = 3;
  localparam int unsigned FN = 4;
  localparam int unsigned DP = 2;
  localparam int unsigned FW = FN * DW;

  logic          clock = 1'b0;
  logic          rst_n;
  logic [3:0]    code_in;
  logic          code_valid;
  logic [3:0]    en_flag;
  logic          FNS02;
  logic [2:0]    FNS03;
  logic [2:0]    FNS04;
  logic          resync;
  logic          err_clr;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          frame_ready;
  logic          overflow;
  logic          range_err;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fns_cac_decoder_2_2 #(
    .DATA_W(DW), .FNS_W(3), .FRAME_N(FN), .DEPTH(DP)
  ) dut (
    .clock(clock), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .en_flag(en_flag), .FNS02(FNS02), .FNS03(FNS03), .FNS04(FNS04),
    .resync(resync), .err_clr(err_clr), .frame_out(frame_out),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .overflow(overflow), .range_err(range_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_part[$];
  logic [FW-1:0] m_fifo[$];
  bit            m_pv;
  int            m_pval;
  bit            m_ovf;
  bit            m_rerr;

  function automatic int model_dec(input logic [3:0] c, input logic [3:0] en,
                                   input logic f2, input logic [2:0] f3,
                                   input logic [2:0] f4);
    logic [3:0] m;
    int v;
    m = c & en;
    v = int'(m[0]);
    if (m[1]) v += int'(f2);
    if (m[2]) v += int'(f3);
    if (m[3]) v += int'(f4);
    return v;
  endfunction

  always @(posedge clock or negedge rst_n) begin
    bit            do_pop;
    bit            ovf_set;
    bit            rerr_set;
    int            v;
    logic [FW-1:0] fr;
    if (!rst_n) begin
      m_part.delete();
      m_fifo.delete();
      m_pv = 0; m_pval = 0; m_ovf = 0; m_rerr = 0;
    end else begin
      do_pop = (m_fifo.size() > 0) && frame_ready;
      if (do_pop) void'(m_fifo.pop_front());
      ovf_set = 0;
      if (resync) m_part.delete();
      else if (m_pv) begin
        m_part.push_back(m_pval);
        if (m_part.size() == FN) begin
          fr = '0;
          foreach (m_part[i]) fr |= FW'(m_part[i]) << (DW * i);
          if (m_fifo.size() < DP) m_fifo.push_back(fr);
          else ovf_set = 1;
          m_part.delete();
        end
      end
      rerr_set = 0;
      if (code_valid) begin
        v = model_dec(code_in, en_flag, FNS02, FNS03, FNS04);
        if (v > 7) begin v = 7; rerr_set = 1; end
        m_pval = v;
      end
      m_pv = code_valid;
      if (ovf_set) m_ovf = 1; else if (err_clr) m_ovf = 0;
      if (rerr_set) m_rerr = 1; else if (err_clr) m_rerr = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(frame_valid), 32'd0);
      chk("rst_frame_out", 32'(frame_out), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_range_err", 32'(range_err), 32'd0);
    end else begin
      chk("valid", 32'(frame_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) chk("frame_out", 32'(frame_out), 32'(m_fifo[0]));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("range_err", 32'(range_err), 32'(m_rerr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [3:0] c);
    code_in = c; code_valid = 1'b1;
    @(posedge clock); #1;
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic pulse_resync();
    resync = 1'b1; @(posedge clock); #1; resync = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; @(posedge clock); #1; err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; code_in = '0; code_valid = 1'b0; en_flag = 4'hF;
    FNS02 = 1'b1; FNS03 = 3'd2; FNS04 = 3'd3;
    resync = 1'b0; err_clr = 1'b0; frame_ready = 1'b1;
    idle(2);
    chk("reset_state_valid", 32'(frame_valid), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // single decode, 1010 -> 3+1
    send(4'b1010);
    chk("dec_1010", 32'(dut.dec_val), 32'd4);
    pulse_resync();

    // bit3 disabled: 1+1+2
    en_flag = 4'b0111;
    send(4'b1111);
    chk("dec_en0111", 32'(dut.dec_val), 32'd4);
    en_flag = 4'hF;
    pulse_resync();
    idle(1);

    // chunks 1,2,3,4 -> 12'h8D1, one-cycle valid pulse
    send(4'b0001); send(4'b0100); send(4'b1000); send(4'b1010);
    @(posedge clock);
    @(negedge clock);
    chk("frame_8d1_valid", 32'(frame_valid), 32'd1);
    chk("frame_8d1", 32'(frame_out), 32'h8D1);
    @(negedge clock);
    chk("frame_8d1_pulse", 32'(frame_valid), 32'd0);
    #1;

    // saturation and sticky range_err
    FNS04 = 3'd5;
    send(4'b1111);
    chk("sat_val", 32'(dut.dec_val), 32'd7);
    chk("range_set", 32'(range_err), 32'd1);
    pulse_resync();
    pulse_clr();
    chk("range_cleared", 32'(range_err), 32'd0);
    err_clr = 1'b1;
    send(4'b1111);
    err_clr = 1'b0;
    chk("range_set_wins", 32'(range_err), 32'd1);
    FNS04 = 3'd3;
    pulse_resync();
    pulse_clr();
    chk("range_cleared2", 32'(range_err), 32'd0);

    // three frames into a stalled consumer: third dropped
    frame_ready = 1'b0;
    repeat (4) send(4'b0001);
    repeat (4) send(4'b0100);
    repeat (4) send(4'b1000);
    @(posedge clock);
    @(negedge clock);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(frame_out), 32'h249);
    frame_ready = 1'b1;
    @(negedge clock);
    chk("ovf_second", 32'(frame_out), 32'h492);
    chk("ovf_second_valid", 32'(frame_valid), 32'd1);
    @(negedge clock);
    chk("ovf_drained", 32'(frame_valid), 32'd0);
    pulse_clr();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // resync drops a partial frame
    send(4'b0001); send(4'b0001);
    idle(1);
    pulse_resync();
    repeat (4) send(4'b1111);
    @(posedge clock);
    @(negedge clock);
    chk("resync_fff", 32'(frame_out), 32'hFFF);
    chk("resync_fff_valid", 32'(frame_valid), 32'd1);
    #1;

    // resync coinciding with the final chunk: no push
    repeat (4) send(4'b0001);
    resync = 1'b1;
    @(posedge clock); #1;
    resync = 1'b0;
    @(negedge clock);
    chk("resync_last_nopush", 32'(frame_valid), 32'd0);
    @(negedge clock);
    chk("resync_last_nopush2", 32'(frame_valid), 32'd0);
    #1;

    // reset mid-frame with a queued frame and a set flag
    frame_ready = 1'b0;
    repeat (4) send(4'b0001);
    FNS04 = 3'd5;
    send(4'b1111);
    send(4'b0001);
    chk("pre_rst_valid", 32'(frame_valid), 32'd1);
    chk("pre_rst_range", 32'(range_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(frame_valid), 32'd0);
    chk("midrst_frame_out", 32'(frame_out), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    chk("midrst_range", 32'(range_err), 32'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    FNS04 = 3'd3;
    frame_ready = 1'b1;
    repeat (4) send(4'b0100);
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_frame", 32'(frame_out), 32'h492);
    chk("post_rst_valid", 32'(frame_valid), 32'd1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
